// File: rtl/exc_pkg.sv
// Shared types and constants for the exception sequencer: FSM states,
// cause codes and PC-mux select encodings.
package exc_pkg;

    typedef enum logic [2:0] {
        S_RUN     = 3'd0,
        S_VECTOR  = 3'd1,
        S_HANDLER = 3'd2,
        S_RETURN  = 3'd3,
        S_HALTED  = 3'd4
    } state_t;

    localparam logic [2:0] CAUSE_NONE = 3'd0;
    localparam logic [2:0] CAUSE_IMEM = 3'd1;
    localparam logic [2:0] CAUSE_ILL  = 3'd2;
    localparam logic [2:0] CAUSE_ALU  = 3'd3;
    localparam logic [2:0] CAUSE_DMEM = 3'd4;
    localparam logic [2:0] CAUSE_DBL  = 3'd7;

    localparam logic [1:0] PCSEL_NEXT = 2'b00;
    localparam logic [1:0] PCSEL_VEC  = 2'b01;
    localparam logic [1:0] PCSEL_EPC  = 2'b10;
    localparam logic [1:0] PCSEL_HOLD = 2'b11;

    // PC-mux select driven while the sequencer sits in a given state.
    function automatic logic [1:0] state_pc_sel(input state_t st);
        logic [1:0] sel;
        case (st)
            S_VECTOR: sel = PCSEL_VEC;
            S_RETURN: sel = PCSEL_EPC;
            S_HALTED: sel = PCSEL_HOLD;
            default:  sel = PCSEL_NEXT;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/exc_priority_enc.sv
// Combinational priority encoder: folds the four exception strobes into a
// single exc flag and the highest-priority cause code.
module exc_priority_enc
    import exc_pkg::*;
(
    input  logic       inst_memory_exception,
    input  logic       invalid_instr,
    input  logic       alu_exception,
    input  logic       data_memory_exception,
    output logic       exc,
    output logic [2:0] cause
);

    // Fixed priority: fetch fault, then illegal opcode, then ALU, then data memory.
    always_comb begin
        exc   = 1'b1;
        cause = CAUSE_NONE;
        if (inst_memory_exception) begin
            cause = CAUSE_IMEM;
        end else if (invalid_instr) begin
            cause = CAUSE_ILL;
        end else if (alu_exception) begin
            cause = CAUSE_ALU;
        end else if (data_memory_exception) begin
            cause = CAUSE_DMEM;
        end else begin
            exc = 1'b0;
        end
    end

endmodule

// File: rtl/exception_sequencer.sv
// Multi-cycle exception sequencer: kills faulting writes, captures EPC/cause,
// steers the PC mux through vector/return and parks the core on halt or double
// fault. Define EXC_SEQ_COUNT_EN to build the saturating exception counter.
module exception_sequencer
    import exc_pkg::*;
#(
    parameter int unsigned     PC_W   = 16,
    parameter logic [PC_W-1:0] VECTOR = 16'h0040
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] pc_in,
    input  logic            inst_memory_exception,
    input  logic            invalid_instr,
    input  logic            alu_exception,
    input  logic            data_memory_exception,
    input  logic            halt_in,
    input  logic            eret_in,
    output logic            kill_wr,
    output logic [1:0]      pc_sel,
    output logic [PC_W-1:0] epc,
    output logic [2:0]      cause,
    output logic            in_handler,
    output logic            halted,
    output logic [7:0]      exc_count
);

    state_t          state_r;
    state_t          next_state_s;
    logic            exc_s;
    logic [2:0]      enc_cause_s;
    logic [PC_W-1:0] epc_r;
    logic [PC_W-1:0] epc_next_s;
    logic [2:0]      cause_r;
    logic [2:0]      cause_next_s;
    logic            kill_wr_s;
    logic [1:0]      pc_sel_r;
    logic            in_handler_r;
    logic            halted_r;

    // The vector address is applied by the PC mux itself; kept as a parameter for it.
    logic [PC_W-1:0] unused_vector_s;
    assign unused_vector_s = VECTOR;

    exc_priority_enc u_enc (
        .inst_memory_exception (inst_memory_exception),
        .invalid_instr         (invalid_instr),
        .alu_exception         (alu_exception),
        .data_memory_exception (data_memory_exception),
        .exc                   (exc_s),
        .cause                 (enc_cause_s)
    );

    // Next-state, capture and write-kill decode.
    always_comb begin
        next_state_s = state_r;
        epc_next_s   = epc_r;
        cause_next_s = cause_r;
        kill_wr_s    = 1'b0;
        case (state_r)
            S_RUN: begin
                kill_wr_s = exc_s;
                if (exc_s) begin
                    next_state_s = S_VECTOR;
                    epc_next_s   = pc_in;
                    cause_next_s = enc_cause_s;
                end else if (halt_in) begin
                    next_state_s = S_HALTED;
                end else begin
                    next_state_s = S_RUN;
                end
            end
            S_VECTOR: begin
                kill_wr_s    = 1'b1;
                next_state_s = S_HANDLER;
            end
            S_HANDLER: begin
                kill_wr_s = exc_s;
                if (exc_s) begin
                    next_state_s = S_HALTED;
                    cause_next_s = CAUSE_DBL;
                end else if (halt_in) begin
                    next_state_s = S_HALTED;
                end else if (eret_in) begin
                    next_state_s = S_RETURN;
                end else begin
                    next_state_s = S_HANDLER;
                end
            end
            S_RETURN: begin
                kill_wr_s    = 1'b1;
                next_state_s = S_RUN;
            end
            S_HALTED: begin
                kill_wr_s    = 1'b1;
                next_state_s = S_HALTED;
            end
            default: begin
                kill_wr_s    = 1'b1;
                next_state_s = S_RUN;
            end
        endcase
    end

    // State, captured fault info and state-decoded outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_RUN;
            epc_r        <= {PC_W{1'b0}};
            cause_r      <= CAUSE_NONE;
            pc_sel_r     <= PCSEL_NEXT;
            in_handler_r <= 1'b0;
            halted_r     <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            epc_r        <= epc_next_s;
            cause_r      <= cause_next_s;
            pc_sel_r     <= state_pc_sel(next_state_s);
            in_handler_r <= (next_state_s == S_HANDLER);
            halted_r     <= (next_state_s == S_HALTED);
        end
    end

`ifdef EXC_SEQ_COUNT_EN
    logic [7:0] exc_count_r;
    logic       count_evt_s;

    assign count_evt_s = exc_s && ((state_r == S_RUN) || (state_r == S_HANDLER));

    // Saturating count of taken exceptions, double faults included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exc_count_r <= 8'h00;
        end else if (count_evt_s && (exc_count_r != 8'hFF)) begin
            exc_count_r <= exc_count_r + 8'h01;
        end else begin
            exc_count_r <= exc_count_r;
        end
    end

    assign exc_count = exc_count_r;
`else
    assign exc_count = 8'h00;
`endif

    assign kill_wr    = kill_wr_s;
    assign pc_sel     = pc_sel_r;
    assign epc        = epc_r;
    assign cause      = cause_r;
    assign in_handler = in_handler_r;
    assign halted     = halted_r;

endmodule

// File: tb/tb_exception_sequencer.sv
// Table-driven self-checking bench for exception_sequencer with a scoreboard
// queue of post-edge expectations; covers EXC_SEQ_COUNT_EN either way.
module tb_exception_sequencer;

    logic        clk;
    logic        rst_n;
    logic [15:0] pc_in;
    logic        inst_memory_exception;
    logic        invalid_instr;
    logic        alu_exception;
    logic        data_memory_exception;
    logic        halt_in;
    logic        eret_in;
    logic        kill_wr;
    logic [1:0]  pc_sel;
    logic [15:0] epc;
    logic [2:0]  cause;
    logic        in_handler;
    logic        halted;
    logic [7:0]  exc_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rst;
        logic [15:0] pc;
        logic        imem, ill, alu, dmem, halt, eret;
        logic        kill;
        logic [1:0]  psel;
        logic [15:0] epc;
        logic [2:0]  cause;
        logic        inh, hlt, evt;
    } vec_t;

    typedef struct {
        logic [1:0]  psel;
        logic [15:0] epc;
        logic [2:0]  cause;
        logic        inh, hlt;
        logic [7:0]  cnt;
    } exp_t;

    vec_t vecs[$];
    exp_t sbq[$];
    logic [7:0] exp_cnt;

    exception_sequencer #(.PC_W(16), .VECTOR(16'h0040)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .pc_in                 (pc_in),
        .inst_memory_exception (inst_memory_exception),
        .invalid_instr         (invalid_instr),
        .alu_exception         (alu_exception),
        .data_memory_exception (data_memory_exception),
        .halt_in               (halt_in),
        .eret_in               (eret_in),
        .kill_wr               (kill_wr),
        .pc_sel                (pc_sel),
        .epc                   (epc),
        .cause                 (cause),
        .in_handler            (in_handler),
        .halted                (halted),
        .exc_count             (exc_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [15:0] pc,
                       input logic imem, input logic ill, input logic alu, input logic dmem,
                       input logic halt, input logic eret, input logic kill,
                       input logic [1:0] psel, input logic [15:0] e, input logic [2:0] c,
                       input logic inh, input logic hlt, input logic evt);
        vec_t v;
        v = '{rst, pc, imem, ill, alu, dmem, halt, eret, kill, psel, e, c, inh, hlt, evt};
        vecs.push_back(v);
    endtask

    task automatic add_rst();
        add(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
            2'b00, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drive(input logic [15:0] pc, input logic imem, input logic ill,
                         input logic alu, input logic dmem, input logic halt, input logic eret);
        pc_in = pc;
        inst_memory_exception = imem;
        invalid_instr = ill;
        alu_exception = alu;
        data_memory_exception = dmem;
        halt_in = halt;
        eret_in = eret;
    endtask

    task automatic compare_outputs(input string tag);
        exp_t e;
        if (sbq.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sbq.pop_front();
            chk({tag, "_pc_sel"}, 32'(pc_sel), 32'(e.psel));
            chk({tag, "_epc"}, 32'(epc), 32'(e.epc));
            chk({tag, "_cause"}, 32'(cause), 32'(e.cause));
            chk({tag, "_in_handler"}, 32'(in_handler), 32'(e.inh));
            chk({tag, "_halted"}, 32'(halted), 32'(e.hlt));
            chk({tag, "_exc_count"}, 32'(exc_count), 32'(e.cnt));
        end
    endtask

    initial begin
        vec_t  v;
        exp_t  e;
        string tag;
        rst_n = 1'b0;
        exp_cnt = 8'h00;
        drive(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        //          rst  pc        im   il   al   dm   ht   er   kill psel   epc       cs   inh  hlt  evt
        add_rst();
        add(1'b0, 16'h0012, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 16'h0012, 3'd3, 1'b0, 1'b0, 1'b1);
        add(1'b0, 16'h0013, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 16'h0012, 3'd3, 1'b1, 1'b0, 1'b0);
        add(1'b0, 16'h0041, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 16'h0012, 3'd3, 1'b0, 1'b0, 1'b0);
        add(1'b0, 16'h0042, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 16'h0012, 3'd3, 1'b0, 1'b0, 1'b0);
        add(1'b0, 16'h0030, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 16'h0030, 3'd1, 1'b0, 1'b0, 1'b1);
        add(1'b0, 16'h0031, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 16'h0030, 3'd1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 16'h0040, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0030, 3'd1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 16'h0041, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 16'h0030, 3'd1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 16'h0044, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 16'h0030, 3'd1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 16'h0050, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 16'h0050, 3'd3, 1'b0, 1'b0, 1'b1);
        add(1'b0, 16'h0051, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 16'h0050, 3'd3, 1'b1, 1'b0, 1'b0);
        add(1'b0, 16'h0060, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 16'h0050, 3'd7, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++)
            add(1'b0, 16'h0070, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 16'h0050, 3'd7, 1'b0, 1'b1, 1'b0);
        add_rst();
        add(1'b0, 16'h0020, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 16'h0021, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0);
        add_rst();
        add(1'b0, 16'h0005, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 16'h0005, 3'd2, 1'b0, 1'b0, 1'b1);
        add(1'b0, 16'h0006, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 16'h0005, 3'd2, 1'b1, 1'b0, 1'b0);
        add(1'b0, 16'h0040, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 16'h0005, 3'd2, 1'b0, 1'b1, 1'b0);
        add_rst();
        add(1'b0, 16'h0007, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 16'h0007, 3'd4, 1'b0, 1'b0, 1'b1);
        add_rst();
        add(1'b0, 16'h0008, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 16'h0008, 3'd4, 1'b0, 1'b0, 1'b1);
        add(1'b0, 16'h0009, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 16'h0008, 3'd4, 1'b1, 1'b0, 1'b0);
        add(1'b0, 16'h0041, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 16'h0008, 3'd4, 1'b0, 1'b0, 1'b0);
        add(1'b0, 16'h0042, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 16'h0008, 3'd4, 1'b0, 1'b0, 1'b0);

        foreach (vecs[k]) begin
            v = vecs[k];
            tag = $sformatf("v%0d", k);
            @(negedge clk);
            if (v.rst) begin
                drive(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                rst_n = 1'b0;
                exp_cnt = 8'h00;
                e = '{2'b00, 16'h0000, 3'd0, 1'b0, 1'b0, 8'h00};
                sbq.push_back(e);
                #1;
                chk({tag, "_rst_kill_wr"}, 32'(kill_wr), 32'd0);
                compare_outputs({tag, "_rst"});
                #1 rst_n = 1'b1;
            end else begin
                drive(v.pc, v.imem, v.ill, v.alu, v.dmem, v.halt, v.eret);
`ifdef EXC_SEQ_COUNT_EN
                if (v.evt && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'h01;
`endif
                e = '{v.psel, v.epc, v.cause, v.inh, v.hlt, exp_cnt};
                sbq.push_back(e);
                #1;
                chk({tag, "_kill_wr"}, 32'(kill_wr), 32'(v.kill));
                @(posedge clk);
                #1;
                compare_outputs(tag);
            end
        end

        // Long fault/eret loop: counter saturation (or stays tied low).
        @(negedge clk);
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk) drive(16'h0100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            @(negedge clk) drive(16'h0040, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            @(negedge clk) drive(16'h0041, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            @(negedge clk) drive(16'h0042, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk);
`ifdef EXC_SEQ_COUNT_EN
        chk("count_saturated", 32'(exc_count), 32'h0000_00FF);
`else
        chk("count_tied_low", 32'(exc_count), 32'h0000_0000);
`endif
        chk("loop_pc_sel", 32'(pc_sel), 32'd0);
        chk("loop_epc", 32'(epc), 32'h0000_0100);
        chk("loop_in_handler", 32'(in_handler), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
